// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer and HI/LO holder for the E stage.
// A start with a mult/div op latches the operands and op and runs for a
// fixed number of cycles. HI/LO are written on the final busy edge.
// mthi/mtlo write HI/LO straight away and never raise busy.
//
//   state | meaning
//   IDLE  | no operation in flight; accepts start
//   RUN   | operation in flight; count holds the busy cycles left
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_instr_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  count_q;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic        is_md_op;
    logic        is_mul_op;
    logic        load;
    logic        commit;
    logic        wr_hi;
    logic        wr_lo;

    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe_u;
    logic [31:0] b_safe_m;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] q_m;
    logic [31:0] r_m;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_valid;

    assign is_md_op  = (op == OP_MULT) || (op == OP_MULTU) ||
                       (op == OP_DIV)  || (op == OP_DIVU);
    assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);

    assign busy     = (state_q == RUN);
    assign stall_md = md_instr_D & (busy | (start & is_md_op));

    // Next-state and control strobes; a start while running is dropped.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        commit  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_md_op) begin
                        load    = 1'b1;
                        state_d = RUN;
                    end else if (op == OP_MTHI) begin
                        wr_hi = 1'b1;
                    end else if (op == OP_MTLO) begin
                        wr_lo = 1'b1;
                    end
                end
            end
            RUN: begin
                if (count_q == 4'd1) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result datapath built from the latched operands. Divides use
    // magnitudes so the quotient truncates toward zero and the remainder
    // follows the dividend's sign. A zero divisor is swapped for one to keep
    // the divider defined; its result is discarded through res_valid.
    always_comb begin
        a_sx     = {{32{a_q[31]}}, a_q};
        b_sx     = {{32{b_q[31]}}, b_q};
        prod_s   = a_sx * b_sx;
        prod_u   = {32'd0, a_q} * {32'd0, b_q};

        a_mag    = a_q[31] ? (32'd0 - a_q) : a_q;
        b_mag    = b_q[31] ? (32'd0 - b_q) : b_q;
        b_safe_u = (b_q == 32'd0) ? 32'd1 : b_q;
        b_safe_m = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_u      = a_q / b_safe_u;
        r_u      = a_q % b_safe_u;
        q_m      = a_mag / b_safe_m;
        r_m      = a_mag % b_safe_m;
        q_s      = (a_q[31] ^ b_q[31]) ? (32'd0 - q_m) : q_m;
        r_s      = a_q[31] ? (32'd0 - r_m) : r_m;

        res_hi    = 32'd0;
        res_lo    = 32'd0;
        res_valid = 1'b0;
        case (op_q)
            OP_MULT: begin
                res_hi    = prod_s[63:32];
                res_lo    = prod_s[31:0];
                res_valid = 1'b1;
            end
            OP_MULTU: begin
                res_hi    = prod_u[63:32];
                res_lo    = prod_u[31:0];
                res_valid = 1'b1;
            end
            OP_DIV: begin
                res_hi    = r_s;
                res_lo    = q_s;
                res_valid = (b_q != 32'd0);
            end
            OP_DIVU: begin
                res_hi    = r_u;
                res_lo    = q_u;
                res_valid = (b_q != 32'd0);
            end
            default: begin
                res_hi    = 32'd0;
                res_lo    = 32'd0;
                res_valid = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand/op latch on accept; latency down-counter while running.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
        end else if (load) begin
            count_q <= is_mul_op ? MULT_CNT : DIV_CNT;
            op_q    <= op;
            a_q     <= rs_val;
            b_q     <= rt_val;
        end else if (state_q == RUN) begin
            count_q <= count_q - 4'd1;
        end
    end

    // HI/LO: committed on the last busy edge, or written directly by mthi/mtlo.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else begin
            if (commit && res_valid) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            if (wr_hi) begin
                hi <= rs_val;
            end
            if (wr_lo) begin
                lo <= rs_val;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl. Stimulus pushes the expected old/new HI/LO
// and busy length for every mult/div it issues; a monitor pops an entry each
// time busy drops and compares it against the registers.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_instr_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .md_instr_D (md_instr_D),
        .busy       (busy),
        .stall_md   (stall_md),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic [31:0] new_hi;
        logic [31:0] new_lo;
        int          n;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] m_hi    = 32'd0;
    logic [31:0] m_lo    = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller is at a negedge. Drives a one-cycle start and returns at posedge+1.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_hi, input logic [31:0] e_lo,
                         input int n, input string name);
        exp_t e;
        e.old_hi = m_hi;
        e.old_lo = m_lo;
        e.new_hi = e_hi;
        e.new_lo = e_lo;
        e.n      = n;
        e.name   = name;
        sb.push_back(e);
        m_hi = e_hi;
        m_lo = e_lo;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd0;
    endtask

    // Waits for busy low, sampled at negedges; returns at that negedge.
    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_total++;
            $display("FAIL %s timeout: busy still 1 after %0d cycles, expected 0", name, k);
        end
    endtask

    // Monitor: counts busy cycles, checks HI/LO hold during busy, compares at busy fall.
    initial begin
        logic prev_busy;
        logic aborted;
        logic hold_ok;
        int   run_cnt;
        exp_t e;
        prev_busy = 1'b0;
        aborted   = 1'b0;
        hold_ok   = 1'b1;
        run_cnt   = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (busy) aborted = 1'b1;
                run_cnt = 0;
                hold_ok = 1'b1;
            end else if (busy) begin
                run_cnt++;
                if (!aborted && sb.size() > 0 &&
                    (hi !== sb[0].old_hi || lo !== sb[0].old_lo)) begin
                    hold_ok = 1'b0;
                end
            end else if (prev_busy) begin
                if (aborted) begin
                    aborted = 1'b0;
                end else if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: busy fell with empty scoreboard, hi=0x%0h lo=0x%0h", hi, lo);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.new_hi});
                    check({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.new_lo});
                    check({e.name, "_busy_cycles"}, 64'(run_cnt), 64'(e.n));
                    check({e.name, "_hold"}, {63'd0, hold_ok}, 64'd1);
                end
                run_cnt = 0;
                hold_ok = 1'b1;
            end
            prev_busy = busy;
        end
    end

    // Directed stimulus.
    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        op         = 3'd0;
        rs_val     = 32'd0;
        rt_val     = 32'd0;
        md_instr_D = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy",  {63'd0, busy}, 64'd0);
        check("reset_hi",    {32'd0, hi}, 64'd0);
        check("reset_lo",    {32'd0, lo}, 64'd0);
        check("reset_stall", {63'd0, stall_md}, 64'd0);

        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, "mult_neg");
        wait_idle("mult_neg");
        issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5, "multu");
        wait_idle("multu");
        issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_neg");
        wait_idle("div_neg");
        issue(3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10, "divu");
        wait_idle("divu");

        // mthi: immediate write, no busy
        start  = 1'b1;
        op     = 3'd5;
        rs_val = 32'h1234_5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd0;
        @(negedge clk);
        check("mthi_hi",   {32'd0, hi}, 64'h1234_5678);
        check("mthi_lo",   {32'd0, lo}, 64'd3);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        m_hi = 32'h1234_5678;

        issue(3'd3, 32'd5, 32'd0, 32'h1234_5678, 32'd3, 10, "div_by_zero");
        wait_idle("div_by_zero");
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, "div_overflow");
        wait_idle("div_overflow");

        // stall with md_instr_D held high
        md_instr_D = 1'b1;
        #1;
        check("stall_idle_before", {63'd0, stall_md}, 64'd0);
        start  = 1'b1;
        op     = 3'd1;
        rs_val = 32'd3;
        rt_val = 32'd4;
        sb.push_back('{m_hi, m_lo, 32'd0, 32'd12, 5, "mult_stall"});
        m_hi = 32'd0;
        m_lo = 32'd12;
        #1;
        check("stall_start_cycle", {63'd0, stall_md}, 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_busy_%0d", i), {63'd0, stall_md}, 64'd1);
        end
        @(negedge clk);
        check("stall_after_busy", {63'd0, stall_md}, 64'd0);
        md_instr_D = 1'b0;

        // no stall when md_instr_D is low
        issue(3'd2, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 5, "multu_nostall");
        begin
            logic any_stall;
            any_stall = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (stall_md) any_stall = 1'b1;
            end
            check("no_stall_md_low", {63'd0, any_stall}, 64'd0);
        end
        wait_idle("multu_nostall");

        // divu with an mtlo attempted while busy, then a back-to-back mult
        issue(3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10, "divu_mtlo_ignored");
        start  = 1'b1;
        op     = 3'd6;
        rs_val = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd0;
        wait_idle("divu_mtlo_ignored");
        issue(3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5, "mult_back_to_back");
        wait_idle("mult_back_to_back");

        // reset in the 3rd busy cycle of a div aborts it
        start  = 1'b1;
        op     = 3'd3;
        rs_val = 32'd100;
        rt_val = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi",   {32'd0, hi}, 64'd0);
        check("abort_lo",   {32'd0, lo}, 64'd0);
        repeat (15) @(negedge clk);
        check("abort_no_commit_busy", {63'd0, busy}, 64'd0);
        check("abort_no_commit_hi",   {32'd0, hi}, 64'd0);
        check("abort_no_commit_lo",   {32'd0, lo}, 64'd0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencer and result holder for the multi-cycle multiply/divide resource in the 5-stage MIPS pipeline; sits in the E stage beside the ALU.
- Latches operands on a start pulse, counts the fixed operation latency and commits HI/LO.
- Raises a stall request to the hazard logic so that any D-stage instruction touching HI/LO is held until the result is ready.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal 1..15).

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage instruction is a valid MDU op this cycle.
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- rs_val  input  32  forwarded rs operand, E stage.
- rt_val  input  32  forwarded rt operand, E stage.
- md_instr_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  output  1  operation in progress.
- stall_md  output  1  stall request to the hazard unit.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset:
  - Outputs: hi=0, lo=0, busy=0.
  - Internal state: state=IDLE, count=0, latched operands cleared.
  - Reset mid-operation aborts the operation; no commit.
- States: IDLE and RUN.
- IDLE:
  - If start and op in 1..4 at edge T: latch rs_val, rt_val and op; load count=MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 from cycle T+1 through T+N (N = latency).
- RUN:
  - count decrements every cycle.
  - At the edge ending cycle T+N: commit HI/LO, busy falls to 0, return to IDLE.
  - New HI/LO values are visible in cycle T+N+1.
  - Back-to-back: a start in the first IDLE cycle is accepted normally.
- mthi/mtlo (op 5/6) with start in IDLE: hi<=rs_val or lo<=rs_val at that edge; no busy; state unchanged.
- start while busy (any op): ignored. The hazard unit guarantees this cannot occur; the block must still not corrupt state.
- Results:
  - mult: signed 64-bit product, hi=[63:32], lo=[31:0].
  - multu: unsigned 64-bit product, same split.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned; lo=quotient, hi=remainder.
  - Divide by zero (rt latched = 0): HI/LO unchanged at commit; busy timing identical.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- stall_md (combinational) = md_instr_D & (busy | (start & op in 1..4)).
  - mthi/mtlo alone never stall.
- hi/lo are registered outputs; mfhi/mflo read them directly.
- The block may compute the result at start or at commit, but hi/lo must not change before the commit edge.

Test Plan:
- Reset, then mult rs=0xFFFFFFFF rt=0x00000002 → busy high for exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFE; hi/lo still 0 during busy.
- multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- div rs=0xFFFFFFF9 (-7) rt=2 → 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Next, divu rs=7 rt=2 → lo=3, hi=1.
- mthi rs=0x12345678, then div by 0 → hi stays 0x12345678 and lo stays at its prior value; busy still lasts 10 cycles.
- md_instr_D=1 held, mult started → stall_md=1 on the start cycle and all 5 busy cycles, 0 in the cycle busy drops. With md_instr_D=0 → stall_md=0 throughout.
- div started, reset asserted at the 3rd busy cycle → next cycle busy=0, hi=lo=0, and no commit occurs later. A start during busy (op=mtlo) is ignored and lo is unchanged.
